// File: rtl/czreg_dp_if.sv
// Port bundle of the dual-read scratchpad register file.
// master drives requests, slave is the register file.
interface czreg_dp_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          xCLR_P;
  logic          xBUSY_P;
  logic [AW-1:0] xREGWA_P;
  logic          xREGWE_P;
  logic [DW-1:0] xREGDI_P;
  logic [AW-1:0] xREGRAA_P;
  logic          xREGREA_P;
  logic [DW-1:0] xREGDOA_P;
  logic [AW-1:0] xREGRAB_P;
  logic          xREGREB_P;
  logic [DW-1:0] xREGDOB_P;

  modport master (
    output xCLR_P, xREGWA_P, xREGWE_P, xREGDI_P,
    output xREGRAA_P, xREGREA_P, xREGRAB_P, xREGREB_P,
    input  xBUSY_P, xREGDOA_P, xREGDOB_P
  );

  modport slave (
    input  xCLR_P, xREGWA_P, xREGWE_P, xREGDI_P,
    input  xREGRAA_P, xREGREA_P, xREGRAB_P, xREGREB_P,
    output xBUSY_P, xREGDOA_P, xREGDOB_P
  );
endinterface

// File: rtl/czreg_dp.sv
// Scratchpad register file: one write port, two registered read ports,
// optional write-to-read bypass and a hardware clear sweep.
module czreg_dp #(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
) (
  input logic       CLK,
  input logic       RST_N,
  czreg_dp_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  state_t        stateNxt;
  logic          busy;
  logic [AW-1:0] clrCnt;
  logic [DW-1:0] ram [2**AW];
  logic          hitA;
  logic          hitB;
  logic [DW-1:0] rdA;
  logic [DW-1:0] rdB;
  logic [DW-1:0] doA;
  logic [DW-1:0] doB;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:  if (bus.xCLR_P) stateNxt = CLEAR;
      CLEAR: if (&clrCnt)    stateNxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign bus.xBUSY_P = busy;

  // Held at zero while idle so every sweep starts at entry 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             clrCnt <= '0;
    else if (state == IDLE) clrCnt <= '0;
    else                    clrCnt <= clrCnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (busy)              ram[clrCnt]       <= '0;
    else if (bus.xREGWE_P) ram[bus.xREGWA_P] <= bus.xREGDI_P;
  end

  assign hitA = (BYPASS != 0) && bus.xREGWE_P &&
                (bus.xREGWA_P == bus.xREGRAA_P);
  assign hitB = (BYPASS != 0) && bus.xREGWE_P &&
                (bus.xREGWA_P == bus.xREGRAB_P);
  assign rdA  = hitA ? bus.xREGDI_P : ram[bus.xREGRAA_P];
  assign rdB  = hitB ? bus.xREGDI_P : ram[bus.xREGRAB_P];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             doA <= '0;
    else if (bus.xREGREA_P) doA <= busy ? '0 : rdA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             doB <= '0;
    else if (bus.xREGREB_P) doB <= busy ? '0 : rdB;
  end

  assign bus.xREGDOA_P = doA;
  assign bus.xREGDOB_P = doB;

endmodule

// File: tb/tb_czreg_dp.sv
// Directed bench for czreg_dp: a bypassing and a non-bypassing instance
// receive identical stimulus.
module tb_czreg_dp;

  logic CLK = 1'b0;
  logic RST_N;
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;

  czreg_dp_if #(.DW(8), .AW(4)) bus1 ();
  czreg_dp_if #(.DW(8), .AW(4)) bus0 ();

  assign bus0.xCLR_P    = bus1.xCLR_P;
  assign bus0.xREGWA_P  = bus1.xREGWA_P;
  assign bus0.xREGWE_P  = bus1.xREGWE_P;
  assign bus0.xREGDI_P  = bus1.xREGDI_P;
  assign bus0.xREGRAA_P = bus1.xREGRAA_P;
  assign bus0.xREGREA_P = bus1.xREGREA_P;
  assign bus0.xREGRAB_P = bus1.xREGRAB_P;
  assign bus0.xREGREB_P = bus1.xREGREB_P;

  czreg_dp #(.DW(8), .AW(4), .BYPASS(1), .CLR_ON_RST(1)) dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  czreg_dp #(.DW(8), .AW(4), .BYPASS(0), .CLR_ON_RST(1)) dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] di;
    logic       rea;
    logic [3:0] raa;
    logic       reb;
    logic [3:0] rab;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [7:0] a0;
    logic [7:0] b0;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idleIn();
    bus1.xCLR_P    = 1'b0;
    bus1.xREGWE_P  = 1'b0;
    bus1.xREGWA_P  = '0;
    bus1.xREGDI_P  = '0;
    bus1.xREGREA_P = 1'b0;
    bus1.xREGRAA_P = '0;
    bus1.xREGREB_P = 1'b0;
    bus1.xREGRAB_P = '0;
  endtask

  task automatic busyLen(input string nm);
    int n = 0;
    while (bus1.xBUSY_P && n < 100) begin
      step();
      n++;
    end
    bus1.xREGWE_P = 1'b0;
    chk(nm, n, 16);
  endtask

  task automatic readAll(input string nm);
    for (int i = 0; i < 16; i++) begin
      bus1.xREGREA_P = 1'b1;
      bus1.xREGRAA_P = 4'(i);
      bus1.xREGREB_P = 1'b1;
      bus1.xREGRAB_P = 4'(15 - i);
      step();
      chk($sformatf("%s A1[%0d]", nm, i), bus1.xREGDOA_P, 0);
      chk($sformatf("%s B1[%0d]", nm, 15 - i), bus1.xREGDOB_P, 0);
      chk($sformatf("%s A0[%0d]", nm, i), bus0.xREGDOA_P, 0);
      chk($sformatf("%s B0[%0d]", nm, 15 - i), bus0.xREGDOB_P, 0);
    end
    bus1.xREGREA_P = 1'b0;
    bus1.xREGREB_P = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      bus1.xREGWE_P = 1'b1;
      bus1.xREGWA_P = 4'(i);
      bus1.xREGDI_P = base + 8'(i);
      step();
    end
    bus1.xREGWE_P = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0,
                8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 4'd0,
                8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[2]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 1'b0, 4'd0,
                8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[3]  = '{1'b1, 4'd5, 8'h11, 1'b0, 4'd0, 1'b0, 4'd0,
                8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[4]  = '{1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b0, 4'd0,
                8'h3C, 8'h00, 8'h11, 8'h00};
    tbl[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0, 4'd0,
                8'h3C, 8'h00, 8'h3C, 8'h00};
    tbl[6]  = '{1'b1, 4'd2, 8'h77, 1'b0, 4'd0, 1'b0, 4'd0,
                8'h3C, 8'h00, 8'h3C, 8'h00};
    tbl[7]  = '{1'b1, 4'd9, 8'h88, 1'b0, 4'd0, 1'b0, 4'd0,
                8'h3C, 8'h00, 8'h3C, 8'h00};
    tbl[8]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd9,
                8'h77, 8'h88, 8'h77, 8'h88};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b1, 4'd9,
                8'h88, 8'h88, 8'h88, 8'h88};
    tbl[10] = '{1'b1, 4'd9, 8'h5A, 1'b1, 4'd3, 1'b1, 4'd9,
                8'hA5, 8'h5A, 8'hA5, 8'h88};
    tbl[11] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 1'b0, 4'd9,
                8'hA5, 8'h5A, 8'hA5, 8'h88};
    tbl[12] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 4'd9,
                8'hA5, 8'h5A, 8'hA5, 8'h5A};

    RST_N = 1'b0;
    idleIn();
    step();
    step();
    chk("rst busy", bus1.xBUSY_P, 1);
    chk("rst doa", bus1.xREGDOA_P, 0);
    chk("rst dob", bus1.xREGDOB_P, 0);
    RST_N = 1'b1;
    busyLen("rst sweep len");
    readAll("post rst");

    for (int i = 0; i < 13; i++) begin
      bus1.xREGWE_P  = tbl[i].we;
      bus1.xREGWA_P  = tbl[i].wa;
      bus1.xREGDI_P  = tbl[i].di;
      bus1.xREGREA_P = tbl[i].rea;
      bus1.xREGRAA_P = tbl[i].raa;
      bus1.xREGREB_P = tbl[i].reb;
      bus1.xREGRAB_P = tbl[i].rab;
      step();
      chk($sformatf("vec%0d A1", i), bus1.xREGDOA_P, tbl[i].a1);
      chk($sformatf("vec%0d B1", i), bus1.xREGDOB_P, tbl[i].b1);
      chk($sformatf("vec%0d A0", i), bus0.xREGDOA_P, tbl[i].a0);
      chk($sformatf("vec%0d B0", i), bus0.xREGDOB_P, tbl[i].b0);
    end
    idleIn();

    fill(8'h10);
    bus1.xREGREA_P = 1'b1;
    bus1.xREGRAA_P = 4'd7;
    bus1.xREGREB_P = 1'b1;
    bus1.xREGRAB_P = 4'd8;
    step();
    chk("fill rd7", bus1.xREGDOA_P, 8'h17);
    chk("fill rd8", bus1.xREGDOB_P, 8'h18);
    idleIn();
    bus1.xCLR_P = 1'b1;
    step();
    bus1.xCLR_P = 1'b0;
    chk("clr busy", bus1.xBUSY_P, 1);
    bus1.xREGWE_P  = 1'b1;
    bus1.xREGWA_P  = 4'd7;
    bus1.xREGDI_P  = 8'hFF;
    bus1.xREGREA_P = 1'b1;
    bus1.xREGRAA_P = 4'd7;
    bus1.xREGREB_P = 1'b1;
    bus1.xREGRAB_P = 4'd8;
    step();
    chk("busy rd A", bus1.xREGDOA_P, 0);
    chk("busy rd B", bus1.xREGDOB_P, 0);
    bus1.xREGREA_P = 1'b0;
    bus1.xREGREB_P = 1'b0;
    begin
      int n = 1;
      while (bus1.xBUSY_P && n < 100) begin
        step();
        n++;
      end
      bus1.xREGWE_P = 1'b0;
      chk("clr sweep len", n, 16);
    end
    readAll("post clr");

    fill(8'h20);
    bus1.xREGREA_P = 1'b1;
    bus1.xREGRAA_P = 4'd4;
    bus1.xREGREB_P = 1'b1;
    bus1.xREGRAB_P = 4'd6;
    step();
    chk("fill2 rd4", bus1.xREGDOA_P, 8'h24);
    chk("fill2 rd6", bus1.xREGDOB_P, 8'h26);
    idleIn();
    bus1.xCLR_P = 1'b1;
    step();
    bus1.xCLR_P = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid busy", bus1.xBUSY_P, 1);
    RST_N = 1'b0;
    #1;
    chk("abort doa", bus1.xREGDOA_P, 0);
    chk("abort dob", bus1.xREGDOB_P, 0);
    chk("abort busy", bus1.xBUSY_P, 1);
    step();
    step();
    RST_N = 1'b1;
    busyLen("restart sweep len");
    readAll("post abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
